// File: rtl/cond_eval4.sv
// Condition-code evaluator on the ALU NZCV flags. It answers valid/ready queries
// through a one-entry response buffer and keeps a saturating count of taken queries.
module cond_eval4 #(
  parameter int unsigned TAG_W = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flag_we,
  input  logic             c,
  input  logic             n,
  input  logic             z,
  input  logic             v,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       cond,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_taken,
  output logic [TAG_W-1:0] resp_tag,
  output logic [3:0]       flags_q,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] eff;
  logic       cond_true;
  logic       accept;

  // A flag write in the same cycle bypasses the register so the query sees it.
  assign eff    = flag_we ? {n, z, c, v} : flags_q;
  assign accept = req_valid & req_ready;

  // eff bit order: [3]=n [2]=z [1]=c [0]=v
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'h0:    cond_true = eff[2];
      4'h1:    cond_true = ~eff[2];
      4'h2:    cond_true = eff[1];
      4'h3:    cond_true = ~eff[1];
      4'h4:    cond_true = eff[3];
      4'h5:    cond_true = ~eff[3];
      4'h6:    cond_true = eff[0];
      4'h7:    cond_true = ~eff[0];
      4'h8:    cond_true = eff[1] & ~eff[2];
      4'h9:    cond_true = ~eff[1] | eff[2];
      4'hA:    cond_true = (eff[3] == eff[0]);
      4'hB:    cond_true = (eff[3] != eff[0]);
      4'hC:    cond_true = ~eff[2] & (eff[3] == eff[0]);
      4'hD:    cond_true = eff[2] | (eff[3] != eff[0]);
      4'hE:    cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (resp_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Handshake outputs; the buffer can refill in the cycle it drains.
  always_comb begin
    resp_valid = (state_q == FULL);
    req_ready  = ~resp_valid | resp_ready;
  end

  // Response payload only changes on accept, so a held response stays stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_taken <= 1'b0;
      resp_tag   <= '0;
    end else if (accept) begin
      resp_taken <= cond_true;
      resp_tag   <= req_tag;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= 4'b0000;
    end else if (flag_we) begin
      flags_q <= {n, z, c, v};
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken_cnt <= '0;
    end else if (clr_cnt) begin
      taken_cnt <= '0;
    end else if (accept && cond_true && (taken_cnt != CNT_MAX)) begin
      taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cond_eval4.sv
// Directed bench for cond_eval4: a default instance and a CNT_W=4 instance share the stimulus.
module tb_cond_eval4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       flag_we, c, n, z, v;
  logic       req_valid, resp_ready, clr_cnt;
  logic [3:0] cond;
  logic [1:0] req_tag;

  logic       req_ready, resp_valid, resp_taken;
  logic [1:0] resp_tag;
  logic [3:0] flags_q;
  logic [7:0] taken_cnt;

  logic       req_ready4, resp_valid4, resp_taken4;
  logic [1:0] resp_tag4;
  logic [3:0] flags_q4;
  logic [3:0] taken_cnt4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cond_eval4 dut (
    .clk(clk), .reset_n(reset_n), .flag_we(flag_we), .c(c), .n(n), .z(z), .v(v),
    .req_valid(req_valid), .req_ready(req_ready), .cond(cond), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_taken(resp_taken),
    .resp_tag(resp_tag), .flags_q(flags_q), .clr_cnt(clr_cnt), .taken_cnt(taken_cnt)
  );

  cond_eval4 #(.TAG_W(2), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .flag_we(flag_we), .c(c), .n(n), .z(z), .v(v),
    .req_valid(req_valid), .req_ready(req_ready4), .cond(cond), .req_tag(req_tag),
    .resp_valid(resp_valid4), .resp_ready(resp_ready), .resp_taken(resp_taken4),
    .resp_tag(resp_tag4), .flags_q(flags_q4), .clr_cnt(clr_cnt), .taken_cnt(taken_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic we, input logic [3:0] nzcv);
    flag_we = we;
    {n, z, c, v} = nzcv;
  endtask

  task automatic query(input logic [3:0] cc, input logic [1:0] tg);
    req_valid = 1'b1;
    cond      = cc;
    req_tag   = tg;
  endtask

  // Condition sweep with flags {n,z,c,v}=0010, expected results hand-computed.
  logic [3:0] sweep_cond [11] = '{4'h8, 4'h9, 4'hC, 4'hD, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'h1};
  logic       sweep_exp  [11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    reset_n = 1'b0;
    set_flags(1'b0, 4'b0000);
    req_valid = 1'b0; resp_ready = 1'b1; clr_cnt = 1'b0;
    cond = 4'h0; req_tag = 2'd0;
    tick(); tick();

    chk("rst_flags", 32'(flags_q), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_taken", 32'(resp_taken), 32'h0);
    chk("rst_resp_tag", 32'(resp_tag), 32'h0);
    chk("rst_cnt", 32'(taken_cnt), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h1);

    reset_n = 1'b1;
    query(4'h0, 2'd1);
    tick();
    chk("eq_valid", 32'(resp_valid), 32'h1);
    chk("eq_taken", 32'(resp_taken), 32'h0);
    chk("eq_tag", 32'(resp_tag), 32'h1);
    chk("eq_cnt", 32'(taken_cnt), 32'h0);

    req_valid = 1'b0;
    set_flags(1'b1, 4'b1000);
    tick();
    chk("drain_valid", 32'(resp_valid), 32'h0);
    chk("flags_n", 32'(flags_q), 32'h8);

    set_flags(1'b0, 4'b0000);
    query(4'hB, 2'd3);
    tick();
    chk("lt_taken", 32'(resp_taken), 32'h1);
    chk("lt_tag", 32'(resp_tag), 32'h3);
    chk("lt_cnt", 32'(taken_cnt), 32'h1);

    query(4'hA, 2'd2);
    tick();
    chk("ge_valid", 32'(resp_valid), 32'h1);
    chk("ge_taken", 32'(resp_taken), 32'h0);
    chk("ge_tag", 32'(resp_tag), 32'h2);
    chk("ge_cnt", 32'(taken_cnt), 32'h1);

    set_flags(1'b1, 4'b0100);
    query(4'h0, 2'd1);
    tick();
    chk("bypass_taken", 32'(resp_taken), 32'h1);
    chk("bypass_flags", 32'(flags_q), 32'h4);
    chk("bypass_cnt", 32'(taken_cnt), 32'h2);

    // Hold the response while flags change and a new query waits.
    resp_ready = 1'b0;
    set_flags(1'b1, 4'b0000);
    query(4'hE, 2'd2);
    #1;
    chk("bp_req_ready", 32'(req_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      set_flags(1'b0, 4'b0000);
      chk("bp_valid", 32'(resp_valid), 32'h1);
      chk("bp_taken", 32'(resp_taken), 32'h1);
      chk("bp_tag", 32'(resp_tag), 32'h1);
      chk("bp_req_ready_hold", 32'(req_ready), 32'h0);
      chk("bp_cnt", 32'(taken_cnt), 32'h2);
    end
    chk("bp_flags", 32'(flags_q), 32'h0);

    resp_ready = 1'b1;
    #1;
    chk("release_req_ready", 32'(req_ready), 32'h1);
    tick();
    chk("release_taken", 32'(resp_taken), 32'h1);
    chk("release_tag", 32'(resp_tag), 32'h2);
    chk("release_cnt", 32'(taken_cnt), 32'h3);

    set_flags(1'b1, 4'b0010);
    for (int i = 0; i < 11; i++) begin
      query(sweep_cond[i], 2'(i));
      tick();
      set_flags(1'b0, 4'b0000);
      chk($sformatf("sweep_cond_%0h", sweep_cond[i]), 32'(resp_taken), 32'(sweep_exp[i]));
    end
    chk("sweep_flags", 32'(flags_q), 32'h2);
    chk("sweep_cnt", 32'(taken_cnt), 32'd9);
    chk("sweep_cnt4", 32'(taken_cnt4), 32'd9);

    query(4'hE, 2'd0);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt8", 32'(taken_cnt), 32'd29);
    chk("sat_cnt4", 32'(taken_cnt4), 32'd15);

    query(4'hF, 2'd3);
    tick();
    chk("nv_taken", 32'(resp_taken), 32'h0);
    chk("nv_cnt4", 32'(taken_cnt4), 32'd15);

    query(4'hE, 2'd1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_cnt8", 32'(taken_cnt), 32'h0);
    chk("clr_cnt4", 32'(taken_cnt4), 32'h0);
    chk("clr_taken", 32'(resp_taken), 32'h1);

    tick();
    chk("post_clr_cnt", 32'(taken_cnt), 32'h1);
    chk("pre_arst_valid", 32'(resp_valid), 32'h1);

    // Asynchronous reset between clock edges.
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(resp_valid), 32'h0);
    chk("arst_flags", 32'(flags_q), 32'h0);
    chk("arst_cnt", 32'(taken_cnt), 32'h0);
    chk("arst_cnt4", 32'(taken_cnt4), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cond_eval4.md
Name: cond_eval4

Overview:
- Consumer end of the ALU flag interface: registers the NZCV flags produced by the 4-bit ALU flag logic.
- Answers condition-code queries (EQ, LT, HI, ...) over a valid/ready request/response handshake.
- Sits between the ALU4 datapath and the branch/predication sequencer; one-entry output buffer, 1-cycle latency, saturating taken counter.

Parameters:
- TAG_W, 2, width of the request tag returned with each response.
- CNT_W, 8, width of the saturating taken-condition counter.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  reset; asynchronous, active-low.
- flag_we  input  1  load c/n/z/v into flag register this cycle.
- c  input  1  carry flag from ALU.
- n  input  1  negative flag from ALU.
- z  input  1  zero flag from ALU.
- v  input  1  overflow flag from ALU.
- req_valid  input  1  condition query valid.
- req_ready  output  1  query accepted when req_valid & req_ready.
- cond  input  4  condition code.
- req_tag  input  TAG_W  opaque tag.
- resp_valid  output  1  response valid.
- resp_ready  input  1  response consumed when resp_valid & resp_ready.
- resp_taken  output  1  condition result.
- resp_tag  output  TAG_W  tag of answered query.
- flags_q  output  4  stored flags {n,z,c,v}.
- clr_cnt  input  1  synchronous clear of taken_cnt.
- taken_cnt  output  CNT_W  count of accepted queries with result 1, saturating.

Behaviour:
- Reset (async, reset_n=0): flags_q=0000, resp_valid=0, resp_taken=0, resp_tag=0, taken_cnt=0, state EMPTY. Reset mid-transaction drops any held response.
- Flag register: on posedge with flag_we=1, flags_q <= {n,z,c,v}. Otherwise flags_q holds.
- Effective flags (eff): incoming {n,z,c,v} when flag_we=1 in the same cycle (bypass); otherwise flags_q.
- Condition codes, evaluated on eff:
  - 0 EQ z; 1 NE !z; 2 CS c; 3 CC !c.
  - 4 MI n; 5 PL !n; 6 VS v; 7 VC !v.
  - 8 HI c&!z; 9 LS !c|z.
  - A GE n==v; B LT n!=v; C GT !z&(n==v); D LE z|(n!=v).
  - E AL 1; F NV 0.
- req_ready = !resp_valid | resp_ready, combinational. Responses pass back-to-back at full rate.
- State machine:
  - EMPTY: accepted query -> FULL.
  - FULL: resp_ready=1 with no new accept -> EMPTY. resp_ready=1 with new accept -> stays FULL, new data. resp_ready=0 -> holds.
  - resp_valid = (state==FULL).
- Latency: query accepted in cycle t; resp_valid/resp_taken/resp_tag valid from cycle t+1.
- Hold rule: while resp_valid & !resp_ready, resp_taken and resp_tag are stable. Later flag updates do not alter a held response.
- Counter:
  - Increments by 1 on each accepted query whose result is 1.
  - Saturates at 2^CNT_W-1.
  - clr_cnt has priority over increment in the same cycle: result is 0.
- cond and req_tag are ignored when no query is accepted.

Test Plan:
- Release reset with z=0, no flag_we; query cond=0 (EQ), tag=1 -> next cycle resp_valid=1, resp_taken=0, resp_tag=1; flags_q=0000, taken_cnt=0.
- flag_we with n=1,z=0,c=0,v=0; next cycle query cond=B (LT) tag=3 -> resp_taken=1, tag=3. Then query cond=A (GE) -> resp_taken=0. taken_cnt=1.
- Same cycle: flag_we with z=1 (others 0) and query cond=0 (EQ) -> resp_taken=1 (bypass); flags_q=0100 the following cycle.
- Backpressure: response held with resp_ready=0 for 3 cycles while flag_we sets z=0 -> resp_taken/resp_tag unchanged, req_ready=0, queued query not accepted. Raise resp_ready with query cond=E pending -> accepted same cycle, next response resp_taken=1.
- CNT_W=4: 20 consecutive accepted cond=E queries -> taken_cnt=15 (saturated). Assert clr_cnt with an accepted cond=E query -> taken_cnt=0.
- Assert reset_n=0 asynchronously while resp_valid=1 -> resp_valid=0, flags_q=0000, taken_cnt=0 immediately, without waiting for a clock edge.
